// File: rtl/push2pull_fifo.sv
// push2pull_fifo: buffering bridge from a push-style producer to a pull-style
// consumer. A circular register FIFO terminates the push_push/push_dat stream
// and re-presents it as pull_rdy/pull_pop/pull_dat. Both ready outputs depend
// only on registered pointer state, so there is no combinational path between
// the two sides.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active-high
//   push_rdy   FIFO can accept one word this cycle
//   push_push  producer writes push_dat this cycle
//   push_dat   write data
//   pull_rdy   head word available this cycle
//   pull_pop   consumer takes pull_dat this cycle
//   pull_dat   head word, all-zero when empty
//   level      current occupancy, 0..DEPTH
module push2pull_fifo #(
   parameter  int unsigned DWIDTH = 32,
   parameter  int unsigned DEPTH  = 4,
   localparam int unsigned AWIDTH = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              push_rdy,
   input  logic              push_push,
   input  logic [DWIDTH-1:0] push_dat,
   output logic              pull_rdy,
   input  logic              pull_pop,
   output logic [DWIDTH-1:0] pull_dat,
   output logic [AWIDTH:0]   level
);

   localparam logic [AWIDTH:0] PtrOne = 1;

   // Pointers carry one extra wrap bit above the index so full and empty can
   // be told apart when the indices match.
   logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [DWIDTH-1:0] mem [DEPTH];

   logic empty;
   logic full;
   logic do_push;
   logic do_pop;

   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]) &&
              (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]);
   end

   // rst gates push_rdy directly so the producer sees not-ready for the whole
   // reset interval, not just from the next edge.
   assign push_rdy = !full && !rst;
   assign pull_rdy = !empty;
   assign pull_dat = pull_rdy ? mem[rd_ptr_q[AWIDTH-1:0]] : '0;
   assign level    = wr_ptr_q - rd_ptr_q;

   // Transfers without the matching ready are protocol violations and are
   // simply dropped.
   assign do_push = push_push && push_rdy;
   assign do_pop  = pull_pop && pull_rdy;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is deliberately not reset; pull_dat masking hides stale words.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q[AWIDTH-1:0]] <= push_dat;
      end
   end

endmodule

// File: tb/tb_push2pull_fifo.sv
// Self-checking bench for push2pull_fifo: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_push2pull_fifo;

   localparam int unsigned DWIDTH = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned AWIDTH = $clog2(DEPTH);

   logic              clk;
   logic              rst;
   logic              push_rdy;
   logic              push_push;
   logic [DWIDTH-1:0] push_dat;
   logic              pull_rdy;
   logic              pull_pop;
   logic [DWIDTH-1:0] pull_dat;
   logic [AWIDTH:0]   level;

   push2pull_fifo #(
      .DWIDTH(DWIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .push_rdy (push_rdy),
      .push_push(push_push),
      .push_dat (push_dat),
      .pull_rdy (pull_rdy),
      .pull_pop (pull_pop),
      .pull_dat (pull_dat),
      .level    (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference model: the FIFO contents as a plain queue, head at index 0.
   logic [DWIDTH-1:0] model_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      int unsigned sz;
      sz = model_q.size();
      check({tag, ".push_rdy"}, 32'(push_rdy), 32'(sz < DEPTH && !rst));
      check({tag, ".pull_rdy"}, 32'(pull_rdy), 32'(sz > 0));
      check({tag, ".pull_dat"}, pull_dat, (sz > 0) ? model_q[0] : 32'h0);
      check({tag, ".level"},    32'(level),    sz);
   endtask

   // One clock cycle: drive inputs, check outputs at the falling edge, then
   // advance the model by the transfers the rules allow from the current state.
   task automatic step(input string tag, input logic push, input logic [DWIDTH-1:0] dat,
                       input logic pop);
      bit pop_ok;
      bit push_ok;
      push_push = push;
      push_dat  = dat;
      pull_pop  = pop;
      @(negedge clk);
      check_outputs(tag);
      pop_ok  = pop && (model_q.size() > 0);
      push_ok = push && (model_q.size() < DEPTH);
      if (pop_ok) begin
         void'(model_q.pop_front());
      end
      if (push_ok) begin
         model_q.push_back(dat);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      push_push = 1'b0;
      push_dat  = '0;
      pull_pop  = 1'b0;
      rst       = 1'b1;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst.push_rdy", 32'(push_rdy), 32'd0);
      check("rst.pull_rdy", 32'(pull_rdy), 32'd0);
      check("rst.pull_dat", pull_dat, 32'd0);
      check("rst.level",    32'(level),    32'd0);
      rst = 1'b0;
      step("post_rst", 1'b0, '0, 1'b0);

      // Fill, then an extra push that must be dropped.
      step("fill0", 1'b1, 32'h11, 1'b0);
      step("fill1", 1'b1, 32'h22, 1'b0);
      step("fill2", 1'b1, 32'h33, 1'b0);
      step("fill3", 1'b1, 32'h44, 1'b0);
      step("fill_extra", 1'b1, 32'h55, 1'b0);
      step("fill_hold", 1'b0, '0, 1'b0);

      // Drain in order, then an ignored pop on empty.
      for (int i = 0; i < 4; i++) begin
         step($sformatf("drain%0d", i), 1'b0, '0, 1'b1);
      end
      step("drain_extra", 1'b0, '0, 1'b1);
      step("drain_idle", 1'b0, '0, 1'b0);

      // Streaming with a one-word prefill; pointers wrap several times.
      step("stream_pre", 1'b1, 32'd0, 1'b0);
      for (int i = 1; i < 20; i++) begin
         step($sformatf("stream%0d", i), 1'b1, 32'(i), 1'b1);
      end
      step("stream_last", 1'b0, '0, 1'b1);
      step("stream_idle", 1'b0, '0, 1'b0);

      // Full plus simultaneous push and pop: pop wins, push dropped.
      for (int i = 0; i < 4; i++) begin
         step($sformatf("fp_fill%0d", i), 1'b1, $urandom, 1'b0);
      end
      step("fp_both", 1'b1, 32'hdead_beef, 1'b1);
      step("fp_after", 1'b0, '0, 1'b0);

      // Mid-cycle reset at level 3; transfers requested that cycle must not land.
      push_push = 1'b1;
      push_dat  = 32'hbad0_bad0;
      pull_pop  = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("midrst.push_rdy", 32'(push_rdy), 32'd0);
      check("midrst.pull_rdy", 32'(pull_rdy), 32'd0);
      check("midrst.pull_dat", pull_dat, 32'd0);
      check("midrst.level",    32'(level),    32'd0);
      model_q.delete();
      @(posedge clk);
      #1;
      push_push = 1'b0;
      pull_pop  = 1'b0;
      rst       = 1'b0;
      step("midrst_idle", 1'b0, '0, 1'b0);
      step("midrst_push", 1'b1, 32'ha5, 1'b0);
      step("midrst_pop", 1'b0, '0, 1'b1);
      step("midrst_end", 1'b0, '0, 1'b0);

      // Randomized traffic, biased both ways to visit full and empty often.
      for (int i = 0; i < 400; i++) begin
         int unsigned bias;
         bias = (i / 50) % 2;
         step($sformatf("rnd%0d", i),
              ($urandom_range(0, 9) < (bias ? 7 : 4)),
              $urandom,
              ($urandom_range(0, 9) < (bias ? 4 : 7)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
